// File: rtl/uart_pwm_cmd_if.sv
// uart_pwm_cmd_if: groups the serial input and the PWM-side outputs of the
// UART command parser. The host/bench side uses the master modport; the
// parser itself uses the slave modport.
interface uart_pwm_cmd_if;
    logic        uart_rx;
    logic [31:0] pwm_value;
    logic        pwm_valid;
    logic        frame_err;
    logic        rx_busy;

    modport master (
        output uart_rx,
        input  pwm_value,
        input  pwm_valid,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  uart_rx,
        output pwm_value,
        output pwm_valid,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_pwm_cmd.sv
// uart_pwm_cmd: 8N1 UART receiver plus frame parser feeding the servo PWM
// stage. A frame is HDR, HI, LO (and CHK = HI^LO when CMD_CHECKSUM_EN is
// defined). The commanded width in microseconds is clamped to MAX_US,
// scaled to clock counts and held on pwm_value until the next good frame.
// Optional feature macro: CMD_CHECKSUM_EN (adds the checksum byte/state).
module uart_pwm_cmd #(
    parameter int         CLK_FREQ     = 27_000_000,
    parameter int         BAUD         = 115200,
    parameter int         MAX_US       = 20000,
    parameter int         DEFAULT_US   = 1500,
    parameter int         TIMEOUT_BITS = 20,
    parameter logic [7:0] HDR_BYTE     = 8'hA5
) (
    input  logic           clk,
    input  logic           rst,
    uart_pwm_cmd_if.slave  bus
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CLKS_PER_US  = CLK_FREQ / 1_000_000;
    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_CNT_W     = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] HALF_LAST = BIT_CNT_W'(HALF_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_ONE   = BIT_CNT_W'(1);
    localparam logic [TO_CNT_W-1:0]  TO_LAST   = TO_CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [TO_CNT_W-1:0]  TO_ONE    = TO_CNT_W'(1);
    localparam logic [15:0]          MAX_US_W  = 16'(MAX_US);
    localparam logic [31:0]          SCALE_W   = 32'(CLKS_PER_US);
    localparam logic [31:0]          DEFAULT_VALUE = 32'(DEFAULT_US * CLKS_PER_US);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

`ifdef CMD_CHECKSUM_EN
    typedef enum logic [1:0] {
        P_WAIT_HDR,
        P_GET_HI,
        P_GET_LO,
        P_GET_CHK
    } parse_state_t;
`else
    typedef enum logic [1:0] {
        P_WAIT_HDR,
        P_GET_HI,
        P_GET_LO
    } parse_state_t;
`endif

    // Synchroniser
    logic rx_meta_q, rx_meta_d;
    logic rx_sync_q, rx_sync_d;

    // Byte receiver
    rx_state_t              rx_state_q, rx_state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [2:0]             bit_idx_q,  bit_idx_d;
    logic [7:0]             shift_q,    shift_d;
    logic                   rx_busy_q,  rx_busy_d;
    logic                   byte_strobe;
    logic                   stop_err;

    // Parser
    parse_state_t           parse_state_q, parse_state_d;
    logic [7:0]             hi_q, hi_d;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]             lo_q, lo_d;
`endif
    logic [TO_CNT_W-1:0]    to_cnt_q, to_cnt_d;
    logic [31:0]            pwm_value_q, pwm_value_d;
    logic                   pwm_valid_q, pwm_valid_d;
    logic                   frame_err_q, frame_err_d;

    logic [15:0]            cmd_us;
    logic [15:0]            us_clamped;
    logic [31:0]            scaled_value;
    logic                   commit;

    // Bit timing, sampling and deserialisation of one 8N1 byte; the strobe and
    // stop error are combinational so the parser acts on the stop-sample edge.
    always_comb begin
        rx_meta_d   = bus.uart_rx;
        rx_sync_d   = rx_meta_q;
        rx_state_d  = rx_state_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_strobe = 1'b0;
        stop_err    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    bit_cnt_d  = '0;
                end
            end
            RX_START: begin
                if (bit_cnt_q == HALF_LAST) begin
                    bit_cnt_d  = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                end
            end
            RX_DATA: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                end
            end
            RX_STOP: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_strobe = 1'b1;
                    end else begin
                        stop_err = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
        rx_busy_d = (rx_state_d != RX_IDLE);
    end

    // Width arithmetic: assemble microseconds, clamp, scale to clock counts.
`ifdef CMD_CHECKSUM_EN
    assign cmd_us = {hi_q, lo_q};
`else
    assign cmd_us = {hi_q, shift_q};
`endif
    assign us_clamped   = (cmd_us > MAX_US_W) ? MAX_US_W : cmd_us;
    assign scaled_value = 32'(us_clamped) * SCALE_W;

    // Frame parser and inter-byte timeout; a byte strobe beats timeout expiry,
    // and a stop-bit error abandons any partial frame.
    always_comb begin
        parse_state_d = parse_state_q;
        hi_d          = hi_q;
`ifdef CMD_CHECKSUM_EN
        lo_d          = lo_q;
`endif
        to_cnt_d      = to_cnt_q;
        pwm_value_d   = pwm_value_q;
        pwm_valid_d   = 1'b0;
        frame_err_d   = 1'b0;
        commit        = 1'b0;
        if (stop_err) begin
            parse_state_d = P_WAIT_HDR;
            to_cnt_d      = '0;
            frame_err_d   = 1'b1;
        end else if (byte_strobe) begin
            to_cnt_d = '0;
            case (parse_state_q)
                P_WAIT_HDR: begin
                    if (shift_q == HDR_BYTE) begin
                        parse_state_d = P_GET_HI;
                    end
                end
                P_GET_HI: begin
                    hi_d          = shift_q;
                    parse_state_d = P_GET_LO;
                end
                P_GET_LO: begin
`ifdef CMD_CHECKSUM_EN
                    lo_d          = shift_q;
                    parse_state_d = P_GET_CHK;
`else
                    commit        = 1'b1;
                    parse_state_d = P_WAIT_HDR;
`endif
                end
`ifdef CMD_CHECKSUM_EN
                P_GET_CHK: begin
                    if (shift_q == (hi_q ^ lo_q)) begin
                        commit = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    parse_state_d = P_WAIT_HDR;
                end
`endif
                default: begin
                    parse_state_d = P_WAIT_HDR;
                end
            endcase
        end else if (parse_state_q != P_WAIT_HDR) begin
            if (to_cnt_q == TO_LAST) begin
                to_cnt_d      = '0;
                frame_err_d   = 1'b1;
                parse_state_d = P_WAIT_HDR;
            end else begin
                to_cnt_d = to_cnt_q + TO_ONE;
            end
        end
        if (commit) begin
            pwm_value_d = scaled_value;
            pwm_valid_d = 1'b1;
        end
    end

    // All state registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_state_q    <= RX_IDLE;
            bit_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            rx_busy_q     <= 1'b0;
            parse_state_q <= P_WAIT_HDR;
            hi_q          <= '0;
`ifdef CMD_CHECKSUM_EN
            lo_q          <= '0;
`endif
            to_cnt_q      <= '0;
            pwm_value_q   <= DEFAULT_VALUE;
            pwm_valid_q   <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            rx_meta_q     <= rx_meta_d;
            rx_sync_q     <= rx_sync_d;
            rx_state_q    <= rx_state_d;
            bit_cnt_q     <= bit_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_busy_q     <= rx_busy_d;
            parse_state_q <= parse_state_d;
            hi_q          <= hi_d;
`ifdef CMD_CHECKSUM_EN
            lo_q          <= lo_d;
`endif
            to_cnt_q      <= to_cnt_d;
            pwm_value_q   <= pwm_value_d;
            pwm_valid_q   <= pwm_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign bus.pwm_value = pwm_value_q;
    assign bus.pwm_valid = pwm_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_pwm_cmd.sv
// tb_uart_pwm_cmd: frame vectors from a table feed a scoreboard of expected
// pwm_value commits; hand-written sequences cover reset mid-frame, timeout,
// start-bit glitch and stop-bit error. A faster baud keeps the run short.
module tb_uart_pwm_cmd;

    localparam int CLK_FREQ  = 27_000_000;
    localparam int TB_BAUD   = 460_800;
    localparam int CPB       = CLK_FREQ / TB_BAUD;
    localparam int HALF      = CPB / 2;
    localparam int TO_CLKS   = 20 * CPB;
    // Cycles from the end of the last driven stop bit to the timeout pulse:
    // 2-flop sync + START entry (3), half bit, 8 data bits, then the
    // stop-sample edge sits CPB before the end of a 10-bit byte.
    localparam int ERR_DELAY = 3 + HALF - CPB + TO_CLKS;
    localparam logic [31:0] DEFAULT_VALUE = 32'd40500;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        bit          corrupt;
        logic [31:0] exp_value;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_pwm_cmd_if bus ();

    uart_pwm_cmd #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (TB_BAUD),
        .MAX_US       (20000),
        .DEFAULT_US   (1500),
        .TIMEOUT_BITS (20),
        .HDR_BYTE     (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 100 MHz-style free-running clock; absolute period is irrelevant.
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    int          valid_cnt = 0;
    int          err_cnt = 0;
    int          stray_cnt = 0;
    int          overlap_cnt = 0;
    int          last_err_cycle = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    logic [31:0] prev_value = '0;
    logic        armed = 1'b0;
    logic [31:0] model_value;
    vec_t        vecs[$];

    // Cycle counter used to time the inter-byte timeout.
    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    // Output monitor: pops the scoreboard on each pwm_valid, counts error
    // pulses, and watches for pwm_value moving without a commit.
    always @(posedge clk) begin
        #1;
        if (bus.pwm_valid && bus.frame_err) overlap_cnt++;
        if (bus.frame_err) begin
            err_cnt++;
            last_err_cycle = cycle;
        end
        if (bus.pwm_valid) begin
            valid_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_commit: got pwm_value=%0d, required no commit", bus.pwm_value);
            end else begin
                exp_v = exp_q.pop_front();
                if (bus.pwm_value !== exp_v) begin
                    bad++;
                    $display("[TB] FAIL commit_value: got %0d, required %0d", bus.pwm_value, exp_v);
                end
            end
        end else if (armed && !rst && bus.pwm_value !== prev_value) begin
            stray_cnt++;
        end
        prev_value = bus.pwm_value;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic idle(input int n);
        bus.uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 byte, LSB first. A bad stop bit is held low for 3/4 of a bit
    // so the receiver's retrigger on the still-low line is seen as a glitch.
    task automatic sendByte(input logic [7:0] b, input bit good_stop);
        bus.uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (good_stop) begin
            bus.uart_rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end else begin
            bus.uart_rx = 1'b0;
            repeat ((CPB * 3) / 4) @(negedge clk);
            bus.uart_rx = 1'b1;
            repeat (CPB - (CPB * 3) / 4) @(negedge clk);
        end
    endtask

    // Full frame; the expected commit is queued before the bytes go out.
    task automatic applyStimulus(input vec_t v);
        logic [7:0] chk;
        chk = v.hi ^ v.lo;
        if (v.corrupt) chk = ~chk;
        if (!v.corrupt) exp_q.push_back(v.exp_value);
        sendByte(8'hA5, 1'b1);
        idle(CPB);
        sendByte(v.hi, 1'b1);
        idle(CPB);
        sendByte(v.lo, 1'b1);
`ifdef CMD_CHECKSUM_EN
        idle(CPB);
        sendByte(chk, 1'b1);
`endif
        idle(CPB);
    endtask

    initial begin : main
        int err_before;
        int valid_before;
        int t_end;
        int delta;
        vec_t v;

        vecs.push_back('{8'h07, 8'hD0, 1'b0, 32'd54000});
`ifdef CMD_CHECKSUM_EN
        vecs.push_back('{8'h07, 8'hD0, 1'b1, 32'd0});
`endif
        vecs.push_back('{8'h03, 8'hE8, 1'b0, 32'd27000});
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 32'd540000});
        vecs.push_back('{8'h4E, 8'h20, 1'b0, 32'd540000});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 32'd0});
        vecs.push_back('{8'h4E, 8'h21, 1'b0, 32'd540000});
        vecs.push_back('{8'h00, 8'hA5, 1'b0, 32'd4455});
        vecs.push_back('{8'hA5, 8'hA5, 1'b0, 32'd540000});

        // Reset with the line idle.
        bus.uart_rx = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_pwm_value", bus.pwm_value, DEFAULT_VALUE);
        checkOutput("reset_pwm_valid", 32'(bus.pwm_valid), 32'd0);
        checkOutput("reset_frame_err", 32'(bus.frame_err), 32'd0);
        checkOutput("reset_rx_busy", 32'(bus.rx_busy), 32'd0);
        rst = 1'b0;
        armed = 1'b1;
        model_value = DEFAULT_VALUE;
        idle(4);

        // A non-header byte while waiting for a frame is silently ignored.
        err_before = err_cnt;
        valid_before = valid_cnt;
        sendByte(8'h12, 1'b1);
        idle(CPB);
        checkOutput("junk_no_err", 32'(err_cnt - err_before), 32'd0);
        checkOutput("junk_no_commit", 32'(valid_cnt - valid_before), 32'd0);

        // Table-driven frames.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            err_before = err_cnt;
            applyStimulus(v);
            idle(4);
            if (!v.corrupt) model_value = v.exp_value;
            checkOutput($sformatf("vec%0d_drained", i), 32'(exp_q.size()), 32'd0);
            checkOutput($sformatf("vec%0d_err_pulses", i), 32'(err_cnt - err_before), v.corrupt ? 32'd1 : 32'd0);
            checkOutput($sformatf("vec%0d_held_value", i), bus.pwm_value, model_value);
        end

        // Reset mid-frame drops the partial frame; trailing bytes are ignored.
        sendByte(8'hA5, 1'b1);
        idle(CPB);
        sendByte(8'h07, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_value = DEFAULT_VALUE;
        checkOutput("midreset_pwm_value", bus.pwm_value, DEFAULT_VALUE);
        checkOutput("midreset_rx_busy", 32'(bus.rx_busy), 32'd0);
        err_before = err_cnt;
        valid_before = valid_cnt;
        idle(CPB);
        sendByte(8'hD0, 1'b1);
`ifdef CMD_CHECKSUM_EN
        idle(CPB);
        sendByte(8'hD7, 1'b1);
`endif
        idle(TO_CLKS + 2 * CPB);
        checkOutput("midreset_no_commit", 32'(valid_cnt - valid_before), 32'd0);
        checkOutput("midreset_no_err", 32'(err_cnt - err_before), 32'd0);

        // Inter-byte timeout after a partial frame, then recovery.
        sendByte(8'hA5, 1'b1);
        idle(CPB);
        err_before = err_cnt;
        sendByte(8'h07, 1'b1);
        t_end = cycle;
        idle(25 * CPB);
        checkOutput("timeout_err_pulses", 32'(err_cnt - err_before), 32'd1);
        delta = last_err_cycle - t_end;
        total++;
        if (delta < ERR_DELAY - 4 || delta > ERR_DELAY + 4) begin
            bad++;
            $display("[TB] FAIL timeout_delay: got %0d cycles, required %0d +/-4", delta, ERR_DELAY);
        end
        v = '{8'h0B, 8'hB8, 1'b0, 32'd81000};
        applyStimulus(v);
        idle(4);
        model_value = 32'd81000;
        checkOutput("timeout_recover_value", bus.pwm_value, model_value);

        // Short low glitch: receiver leaves IDLE briefly, then gives up quietly.
        err_before = err_cnt;
        valid_before = valid_cnt;
        bus.uart_rx = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("glitch_busy_high", 32'(bus.rx_busy), 32'd1);
        repeat (5) @(negedge clk);
        idle(CPB);
        checkOutput("glitch_busy_low", 32'(bus.rx_busy), 32'd0);
        checkOutput("glitch_no_err", 32'(err_cnt - err_before), 32'd0);
        checkOutput("glitch_no_commit", 32'(valid_cnt - valid_before), 32'd0);

        // Stop bit low mid-frame: one error, parser back to waiting for header.
        err_before = err_cnt;
        sendByte(8'hA5, 1'b1);
        idle(CPB);
        sendByte(8'h07, 1'b0);
        idle(CPB);
        checkOutput("stopbit_err_pulses", 32'(err_cnt - err_before), 32'd1);
        checkOutput("stopbit_value_kept", bus.pwm_value, model_value);
        v = '{8'h01, 8'hF4, 1'b0, 32'd13500};
        applyStimulus(v);
        idle(4);
        model_value = 32'd13500;
        checkOutput("stopbit_recover_value", bus.pwm_value, model_value);

        // Global invariants over the whole run.
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("no_stray_value_change", 32'(stray_cnt), 32'd0);
        checkOutput("no_valid_err_overlap", 32'(overlap_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_pwm_cmd.md
Name: uart_pwm_cmd

Overview:
UART receiver and command parser that sits directly upstream of the servo PWM generator. It deserialises 8N1 bytes from the host and parses fixed-format frames carrying a pulse width in microseconds. It converts that width to 27 MHz clock counts and drives the 32-bit pulse-width input of the PWM stage, holding the last accepted value between frames.

Parameters:
CLK_FREQ, 27_000_000, system clock frequency in Hz
BAUD, 115200, UART bit rate
CLKS_PER_BIT, CLK_FREQ/BAUD (234), clocks per UART bit, integer-truncated
CLKS_PER_US, CLK_FREQ/1_000_000 (27), clocks per microsecond
MAX_US, 20000, clamp ceiling for the commanded width in us
DEFAULT_US, 1500, width loaded at reset (servo centre)
TIMEOUT_BITS, 20, inter-byte timeout in bit times
HDR_BYTE, 8'hA5, frame header

Ports:
clk  in  1  system clock, 27 MHz
rst  in  1  synchronous reset, active-high
uart_rx  in  1  asynchronous serial input, idle high
pwm_value  out  32  pulse width in clock counts, to the PWM stage pulse-width input
pwm_valid  out  1  one-cycle pulse when pwm_value updates
frame_err  out  1  one-cycle pulse on any rejected byte or frame
rx_busy  out  1  high while the byte receiver is outside IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - pwm_value = DEFAULT_US*CLKS_PER_US (40500).
  - pwm_valid, frame_err and rx_busy = 0.
  - Synchroniser flops = 1.
  - Both FSMs return to their initial state. Reset mid-byte or mid-frame discards all partial data.
- uart_rx passes through a 2-flop synchroniser. All logic uses the synchronised signal.
- Byte receiver FSM:
  - IDLE: wait for the synchronised line to go low.
  - START: count CLKS_PER_BIT/2 clocks, then re-sample. If high, treat as a glitch and return to IDLE with no error. If low, go to DATA.
  - DATA: sample 8 bits LSB-first, each CLKS_PER_BIT clocks apart (mid-bit).
  - STOP: sample after a further CLKS_PER_BIT clocks.
    - Stop bit = 1: emit an internal byte strobe with the data.
    - Stop bit = 0: framing error. Pulse frame_err, discard the byte, reset the parser to WAIT_HDR.
    - Both cases return to IDLE.
- Parser FSM (advances only on a byte strobe):
  - WAIT_HDR: a byte equal to HDR_BYTE goes to GET_HI. Any other byte is ignored silently.
  - GET_HI: latch the high byte, go to GET_LO.
  - GET_LO: latch the low byte. Next state is GET_CHK when CMD_CHECKSUM_EN is defined, otherwise commit.
  - GET_CHK: see Optional Feature.
  - A byte equal to HDR_BYTE in a data position is treated as data; there is no mid-frame resync.
- Commit:
  - us = {hi,lo}, 16-bit unsigned.
  - us_clamped = min(us, MAX_US).
  - pwm_value = us_clamped*CLKS_PER_US, max 65535*27 = 1,769,445, so 21 bits, zero-extended to 32.
  - pwm_value and pwm_valid update in the cycle after the final byte's stop-bit sample. pwm_valid is high for exactly that one cycle.
  - Parser returns to WAIT_HDR.
- Timeout:
  - Runs while the parser is outside WAIT_HDR. It counts clocks since the last byte strobe.
  - When the count reaches TIMEOUT_BITS*CLKS_PER_BIT, pulse frame_err and return the parser to WAIT_HDR.
  - A byte strobe in the same cycle as expiry takes priority: the byte is consumed and the counter restarts.
- pwm_valid and frame_err are never asserted in the same cycle.
- pwm_value is stable between commits and unaffected by errors.

Optional Feature:
Macro CMD_CHECKSUM_EN.
- Defined: 4-byte frame (HDR, HI, LO, CHK).
  - CHK equal to HI^LO commits the frame.
  - CHK mismatch pulses frame_err; pwm_value is unchanged.
  - Either way the parser returns to WAIT_HDR.
- Not defined: 3-byte frame (HDR, HI, LO). The GET_CHK state and comparator are not synthesised, and commit follows GET_LO.

Test Plan:
1. Assert rst for 2 cycles with uart_rx=1 -> pwm_value=40500; pwm_valid=frame_err=rx_busy=0.
2. With checksum enabled, send bytes A5 07 D0 D7 at 234 clk/bit -> pwm_value=54000 (2000 us); pwm_valid high exactly one cycle; frame_err stays 0.
3. Send A5 FF FF 00 -> width clamped to 20000 us; pwm_value=540000 with one pwm_valid pulse.
4. Send A5 07 D0 00 (bad checksum) -> one frame_err pulse; pwm_value keeps its prior value; a following A5 03 E8 EB frame -> pwm_value=27000.
5. Send A5 07, then hold the line idle for 25 bit times -> one frame_err pulse at 20*234 clocks after the 07 strobe; a next full valid frame is accepted.
6. Two stimuli in sequence:
   - Low glitch of 100 clocks -> no byte, no frame_err, rx_busy returns to 0.
   - Byte with stop bit forced low -> one frame_err pulse, parser back in WAIT_HDR.
